// File: rtl/updown_count_controller_if.sv
// Command/status bundle between a requester and the up/down count controller.
// The requester drives the command and the step controls; the controller returns counter status.
interface updown_count_controller_if #(
  parameter int n = 3
) ();
  logic         cmd_valid;
  logic         cmd_ready;
  logic [n-1:0] cmd_target;
  logic         tick;
  logic         pause;
  logic         abort;
  logic [n-1:0] Q;
  logic         sel;
  logic         busy;
  logic         done;
  logic [n-1:0] remaining;

  modport master (
    output cmd_valid, cmd_target, tick, pause, abort,
    input  cmd_ready, Q, sel, busy, done, remaining
  );

  modport slave (
    input  cmd_valid, cmd_target, tick, pause, abort,
    output cmd_ready, Q, sel, busy, done, remaining
  );
endinterface

// File: rtl/updown_count_controller.sv
// Sequencer that steps an n-bit up/down counter toward commanded targets,
// one step per enabled tick, with a one-cycle done pulse on completion.
module updown_count_controller #(
  parameter int           n         = 3,
  parameter logic [n-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  updown_count_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [n-1:0] ONE = n'(1);

  state_t       state;
  logic [n-1:0] q_r;
  logic [n-1:0] remaining_r;
  logic         sel_r;
  logic         busy_r;
  logic         done_r;
  logic         cmd_ready_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      q_r         <= RESET_VAL;
      remaining_r <= '0;
      sel_r       <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // abort has no meaning here; a coincident command is still taken
          if (bus.cmd_valid) begin
            cmd_ready_r <= 1'b0;
            if (bus.cmd_target == q_r) begin
              done_r <= 1'b1;
              state  <= DONE;
            end else if (bus.cmd_target > q_r) begin
              sel_r       <= 1'b1;
              remaining_r <= bus.cmd_target - q_r;
              busy_r      <= 1'b1;
              state       <= RUN;
            end else begin
              sel_r       <= 1'b0;
              remaining_r <= q_r - bus.cmd_target;
              busy_r      <= 1'b1;
              state       <= RUN;
            end
          end
        end

        RUN: begin
          if (bus.abort) begin
            remaining_r <= '0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
            state       <= IDLE;
          end else if (!bus.pause && bus.tick) begin
            // step count is bounded by the distance, so q_r cannot wrap
            q_r         <= sel_r ? q_r + ONE : q_r - ONE;
            remaining_r <= remaining_r - ONE;
            if (remaining_r == ONE) begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
              state  <= DONE;
            end
          end
        end

        DONE: begin
          done_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          state       <= IDLE;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.Q         = q_r;
  assign bus.sel       = sel_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.remaining = remaining_r;
  assign bus.cmd_ready = cmd_ready_r;

endmodule

// File: tb/tb_updown_count_controller.sv
// Bench for updown_count_controller: per-cycle vector table through a scoreboard
// queue, followed by full-range sweeps with bounded waits on done.
module tb_updown_count_controller;

  logic clk = 1'b0;
  logic reset;

  updown_count_controller_if #(.n(3)) u_if ();

  updown_count_controller #(.n(3), .RESET_VAL(3'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [2:0] tgt;
    logic       tk;
    logic       ps;
    logic       ab;
    logic [2:0] q;
    logic       s;
    logic       bz;
    logic       dn;
    logic [2:0] rem;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  function automatic void add(int rst, int vld, int tgt, int tk, int ps, int ab,
                              int q, int s, int bz, int dn, int rem, int rdy);
    vec_t v;
    v.rst = rst[0]; v.vld = vld[0]; v.tgt = tgt[2:0];
    v.tk  = tk[0];  v.ps  = ps[0];  v.ab  = ab[0];
    v.q   = q[2:0]; v.s   = s[0];   v.bz  = bz[0];
    v.dn  = dn[0];  v.rem = rem[2:0]; v.rdy = rdy[0];
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int idx, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic sweep(int tgt, int exp_sel, int exp_cycles);
    int cycles;
    int last_q;
    u_if.cmd_valid  = 1'b1;
    u_if.cmd_target = tgt[2:0];
    u_if.tick       = 1'b1;
    @(posedge clk); #1;
    u_if.cmd_valid = 1'b0;
    chk("sweep_busy", tgt, int'(u_if.busy), 1);
    chk("sweep_sel", tgt, int'(u_if.sel), exp_sel);
    cycles = 0;
    last_q = int'(u_if.Q);
    while (!u_if.done && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      // every step must move exactly one count in the chosen direction
      if (int'(u_if.Q) != last_q + (exp_sel ? 1 : -1))
        chk("sweep_step", cycles, int'(u_if.Q), last_q + (exp_sel ? 1 : -1));
      last_q = int'(u_if.Q);
    end
    chk("sweep_done_seen", tgt, int'(u_if.done), 1);
    chk("sweep_latency", tgt, cycles, exp_cycles);
    chk("sweep_q", tgt, int'(u_if.Q), tgt);
    @(posedge clk); #1;
    chk("sweep_done_clear", tgt, int'(u_if.done), 0);
    chk("sweep_ready", tgt, int'(u_if.cmd_ready), 1);
  endtask

  initial begin
    vec_t v;
    vec_t e;
    reset = 1'b0;
    u_if.cmd_valid = 1'b0; u_if.cmd_target = '0;
    u_if.tick = 1'b0; u_if.pause = 1'b0; u_if.abort = 1'b0;

    //   rst vld tgt tk ps ab |  Q sel busy done rem rdy
    // reset for two cycles
    add(1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1);
    // 0 -> 5 with tick held
    add(0, 1, 5, 1, 0, 0,   0, 1, 1, 0, 5, 0);
    add(0, 0, 5, 1, 0, 0,   1, 1, 1, 0, 4, 0);
    add(0, 0, 5, 1, 0, 0,   2, 1, 1, 0, 3, 0);
    add(0, 0, 5, 1, 0, 0,   3, 1, 1, 0, 2, 0);
    add(0, 0, 5, 1, 0, 0,   4, 1, 1, 0, 1, 0);
    add(0, 0, 5, 1, 0, 0,   5, 1, 0, 1, 0, 0);
    add(0, 0, 5, 1, 0, 0,   5, 1, 0, 0, 0, 1);
    // 5 -> 2 with tick toggling
    add(0, 1, 2, 0, 0, 0,   5, 0, 1, 0, 3, 0);
    add(0, 0, 2, 1, 0, 0,   4, 0, 1, 0, 2, 0);
    add(0, 0, 2, 0, 0, 0,   4, 0, 1, 0, 2, 0);
    add(0, 0, 2, 1, 0, 0,   3, 0, 1, 0, 1, 0);
    add(0, 0, 2, 0, 0, 0,   3, 0, 1, 0, 1, 0);
    add(0, 0, 2, 1, 0, 0,   2, 0, 0, 1, 0, 0);
    add(0, 0, 2, 0, 0, 0,   2, 0, 0, 0, 0, 1);
    // 2 -> 7, pause three cycles, abort at 4
    add(0, 1, 7, 0, 0, 0,   2, 1, 1, 0, 5, 0);
    add(0, 0, 7, 1, 0, 0,   3, 1, 1, 0, 4, 0);
    add(0, 0, 7, 1, 0, 0,   4, 1, 1, 0, 3, 0);
    add(0, 0, 7, 1, 1, 0,   4, 1, 1, 0, 3, 0);
    add(0, 0, 7, 1, 1, 0,   4, 1, 1, 0, 3, 0);
    add(0, 0, 7, 1, 1, 0,   4, 1, 1, 0, 3, 0);
    add(0, 0, 7, 1, 1, 1,   4, 1, 0, 0, 0, 1);
    add(0, 0, 7, 1, 0, 0,   4, 1, 0, 0, 0, 1);
    // zero-distance command, abort alongside it in IDLE
    add(0, 1, 4, 1, 0, 1,   4, 1, 0, 1, 0, 0);
    add(0, 0, 4, 1, 0, 0,   4, 1, 0, 0, 0, 1);
    // 4 -> 1 to set up the reset-mid-run case
    add(0, 1, 1, 0, 0, 0,   4, 0, 1, 0, 3, 0);
    add(0, 0, 1, 1, 0, 0,   3, 0, 1, 0, 2, 0);
    add(0, 0, 1, 1, 0, 0,   2, 0, 1, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0,   1, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 1);
    // 1 -> 6 with cmd_valid held through RUN, reset at 3
    add(0, 1, 6, 0, 0, 0,   1, 1, 1, 0, 5, 0);
    add(0, 1, 6, 1, 0, 0,   2, 1, 1, 0, 4, 0);
    add(0, 1, 6, 1, 0, 0,   3, 1, 1, 0, 3, 0);
    add(1, 1, 6, 0, 0, 0,   0, 1, 0, 0, 0, 1);
    add(0, 1, 6, 0, 0, 0,   0, 1, 1, 0, 6, 0);
    add(0, 0, 6, 0, 0, 1,   0, 1, 0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      reset           = v.rst;
      u_if.cmd_valid  = v.vld;
      u_if.cmd_target = v.tgt;
      u_if.tick       = v.tk;
      u_if.pause      = v.ps;
      u_if.abort      = v.ab;
      exp_q.push_back(v);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk("Q",         i, int'(u_if.Q),         int'(e.q));
      chk("sel",       i, int'(u_if.sel),       int'(e.s));
      chk("busy",      i, int'(u_if.busy),      int'(e.bz));
      chk("done",      i, int'(u_if.done),      int'(e.dn));
      chk("remaining", i, int'(u_if.remaining), int'(e.rem));
      chk("cmd_ready", i, int'(u_if.cmd_ready), int'(e.rdy));
    end

    reset = 1'b0;
    u_if.cmd_valid = 1'b0; u_if.pause = 1'b0; u_if.abort = 1'b0;
    // full-range sweeps from Q=0: both ends without wrap
    sweep(7, 1, 7);
    sweep(0, 0, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
